// File: rtl/hoeraa.sv
// Registered approximate adder: exact upper field, constant-ones low field,
// with the carry into the exact field taken from bit K-1 only.
module hoeraa #(
  parameter int N = 16,
  parameter int K = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         in_valid,
  output logic [N-1:0] S,
  output logic         Co,
  output logic         out_valid
);

  logic         carry_k;
  logic [N-K:0] exact_sum;
  logic [N-1:0] s_next;
  logic         co_next;
  logic [N-1:0] s_reg;
  logic         co_reg;
  logic         valid_reg;

  assign carry_k   = X[K-1] & Y[K-1];
  assign exact_sum = {1'b0, X[N-1:K]} + {1'b0, Y[N-1:K]} + {{(N-K){1'b0}}, carry_k};

  // Bits below K-1 are never computed; they are tied high.
  generate
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_low_ones
      assign s_next[gi] = 1'b1;
    end
  endgenerate

  assign s_next[K-1]   = (X[K-1] ^ Y[K-1]) | (X[K-2] & Y[K-2]);
  assign s_next[N-1:K] = exact_sum[N-K-1:0];
  assign co_next       = exact_sum[N-K];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg     <= '0;
      co_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        s_reg  <= s_next;
        co_reg <= co_next;
      end
    end
  end

  assign S         = s_reg;
  assign Co        = co_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_hoeraa.sv
// Directed table-driven bench for hoeraa (N=16, K=11) with reset and hold sequences.
module tb_hoeraa;

  localparam int N = 16;
  localparam int K = 11;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         in_valid;
  logic [N-1:0] S;
  logic         Co;
  logic         out_valid;

  int applied;
  int miscompares;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t vecs [9];

  hoeraa #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .in_valid(in_valid),
    .S(S), .Co(Co), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] exp_s,
                       input logic exp_co, input logic exp_v);
    applied++;
    if (S !== exp_s || Co !== exp_co || out_valid !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got S=%h Co=%b out_valid=%b, expected S=%h Co=%b out_valid=%b",
               name, S, Co, out_valid, exp_s, exp_co, exp_v);
    end else begin
      $display("ok   %s: S=%h Co=%b out_valid=%b", name, S, Co, out_valid);
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;

    vecs[0] = '{16'h0001, 16'h0001, 16'h03FF, 1'b0};
    vecs[1] = '{16'h00FF, 16'h00FF, 16'h03FF, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h5555, 16'hAAAA, 16'hFFFF, 1'b0};
    vecs[4] = '{16'h8001, 16'h0101, 16'h83FF, 1'b0};
    vecs[5] = '{16'h0400, 16'h0400, 16'h0BFF, 1'b0}; // carry from bit K-1 only
    vecs[6] = '{16'h0200, 16'h0200, 16'h07FF, 1'b0}; // bit K-2 generate sets S[K-1]
    vecs[7] = '{16'hF800, 16'h0800, 16'h03FF, 1'b1}; // exact-field carry out
    vecs[8] = '{16'h0000, 16'h0000, 16'h03FF, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    X        = '0;
    Y        = '0;
    #1;
    check("reset_async", 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_release_idle", 16'h0000, 1'b0, 1'b0);

    // back-to-back valid samples
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      X        = vecs[i].x;
      Y        = vecs[i].y;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d %h+%h", i, vecs[i].x, vecs[i].y),
            vecs[i].s, vecs[i].co, 1'b1);
    end

    // load a distinctive value, then hold with in_valid low and changing inputs
    @(negedge clk);
    X = 16'hF800; Y = 16'h0800; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("load_before_hold", 16'h03FF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      X = 16'h1234 + 16'(i);
      Y = 16'h4321;
      @(posedge clk);
      #1;
      check($sformatf("hold%0d", i), 16'h03FF, 1'b1, 1'b0);
    end

    // valid result, then asynchronous reset mid-cycle
    @(negedge clk);
    X = 16'hFFFF; Y = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_valid", 16'hFFFF, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_midcycle", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_with_valid", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    X = 16'h5555; Y = 16'hAAAA; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", 16'hFFFF, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("valid_drops", 16'hFFFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
